// File: rtl/cordic_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cordic_arbiter
// Description : Shares a single CORDIC core between two requesters (A = id 0,
//               B = id 1) using round-robin arbitration and valid/ready
//               handshakes. For each job the core is held in reset while the
//               latched operands are presented, released, and the result is
//               captured on core_valid and returned tagged with its owner.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   W              operand/result width (signed), must match the core
//   TIMEOUT_CYCLES watchdog limit in RUN (optional feature only)
// Optional feature macro:
//   CORDIC_ARBITER_TIMEOUT_EN - builds a RUN-state watchdog; on expiry the
//   result is zeroed and resp_err is raised. When undefined, RUN waits for
//   core_valid indefinitely and resp_err is tied to 0.
// Ports:
//   clk, reset                      clock (rising edge), async active-high reset
//   req_valid/req_ready [1:0]       per-requester request handshake
//   req_is_direct [1:0]             1 = rotation, 0 = vectoring
//   req_x/req_y/req_z [2*W-1:0]     packed operands, requester i in [i*W +: W]
//   resp_valid/resp_ready           response handshake
//   resp_id                         owner of the current result
//   resp_x/resp_y/resp_z [W-1:0]    result
//   resp_err                        watchdog abort flag
//   busy                            high in any state other than IDLE
//   core_reset                      core reset, high = core held
//   core_is_direct, core_x/y/z      mode and operands to the core
//   core_x_out/y_out/z_out, core_valid  results from the core
// ============================================================================
module cordic_arbiter #(
  parameter int W              = 16,
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [1:0]     req_valid,
  output logic [1:0]     req_ready,
  input  logic [1:0]     req_is_direct,
  input  logic [2*W-1:0] req_x,
  input  logic [2*W-1:0] req_y,
  input  logic [2*W-1:0] req_z,
  output logic           resp_valid,
  input  logic           resp_ready,
  output logic           resp_id,
  output logic [W-1:0]   resp_x,
  output logic [W-1:0]   resp_y,
  output logic [W-1:0]   resp_z,
  output logic           resp_err,
  output logic           busy,
  output logic           core_reset,
  output logic           core_is_direct,
  output logic [W-1:0]   core_x,
  output logic [W-1:0]   core_y,
  output logic [W-1:0]   core_z,
  input  logic [W-1:0]   core_x_out,
  input  logic [W-1:0]   core_y_out,
  input  logic [W-1:0]   core_z_out,
  input  logic           core_valid
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t         r_state;
  state_t         w_state_next;

  logic           r_last_grant;
  logic           r_resp_id;
  logic           r_core_reset;
  logic           r_is_direct;
  logic [W-1:0]   r_op_x;
  logic [W-1:0]   r_op_y;
  logic [W-1:0]   r_op_z;
  logic [W-1:0]   r_res_x;
  logic [W-1:0]   r_res_y;
  logic [W-1:0]   r_res_z;

  logic           w_req_any;
  logic           w_grant;
  logic           w_accept;
  logic           w_timeout;

  // --------------------------------------------------------------------------
  // Round-robin grant: a lone requester always wins; on contention the
  // requester that did not win last time is chosen.
  // --------------------------------------------------------------------------
  assign w_req_any = |req_valid;
  assign w_grant   = (req_valid == 2'b11) ? ~r_last_grant : req_valid[1];
  assign w_accept  = (r_state == S_IDLE) && w_req_any;

  always_comb begin
    req_ready = 2'b00;
    if (w_accept) begin
      req_ready[w_grant] = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Optional watchdog in RUN
  // --------------------------------------------------------------------------
`ifdef CORDIC_ARBITER_TIMEOUT_EN
  localparam int c_WD_BITS = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_WD_BITS-1:0] c_WD_LIMIT = c_WD_BITS'(TIMEOUT_CYCLES);

  logic [c_WD_BITS-1:0] r_wd_cnt;
  logic                 r_err;

  // Held at zero outside RUN, so it is cleared on every entry into RUN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wd_cnt <= '0;
    end else if (r_state != S_RUN) begin
      r_wd_cnt <= '0;
    end else if (r_wd_cnt != c_WD_LIMIT) begin
      r_wd_cnt <= r_wd_cnt + 1'b1;
    end
  end

  assign w_timeout = (r_state == S_RUN) && (r_wd_cnt == c_WD_LIMIT) && !core_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (w_timeout) begin
      r_err <= 1'b1;
    end else if ((r_state == S_RESP) && resp_ready) begin
      r_err <= 1'b0;
    end
  end

  assign resp_err = r_err;
`else
  assign w_timeout = 1'b0;
  assign resp_err  = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (w_req_any)                w_state_next = S_LOAD;
      S_LOAD:                               w_state_next = S_RUN;
      S_RUN:  if (core_valid || w_timeout)  w_state_next = S_RESP;
      S_RESP: if (resp_ready)               w_state_next = S_IDLE;
      default:                              w_state_next = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: operand latch, result capture, core reset sequencing
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_grant <= 1'b1;
      r_resp_id    <= 1'b0;
      r_core_reset <= 1'b1;
      r_is_direct  <= 1'b0;
      r_op_x       <= '0;
      r_op_y       <= '0;
      r_op_z       <= '0;
      r_res_x      <= '0;
      r_res_y      <= '0;
      r_res_z      <= '0;
    end else begin
      // Core runs only while the FSM sits in RUN; registered to keep the
      // core reset glitch-free.
      r_core_reset <= (w_state_next != S_RUN);

      if (w_accept) begin
        r_last_grant <= w_grant;
        r_resp_id    <= w_grant;
        r_is_direct  <= req_is_direct[w_grant];
        r_op_x       <= w_grant ? req_x[2*W-1:W] : req_x[W-1:0];
        r_op_y       <= w_grant ? req_y[2*W-1:W] : req_y[W-1:0];
        r_op_z       <= w_grant ? req_z[2*W-1:W] : req_z[W-1:0];
      end

      if (r_state == S_RUN) begin
        if (core_valid) begin
          r_res_x <= core_x_out;
          r_res_y <= core_y_out;
          r_res_z <= core_z_out;
        end else if (w_timeout) begin
          r_res_x <= '0;
          r_res_y <= '0;
          r_res_z <= '0;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign busy           = (r_state != S_IDLE);
  assign resp_valid     = (r_state == S_RESP);
  assign resp_id        = r_resp_id;
  assign resp_x         = r_res_x;
  assign resp_y         = r_res_y;
  assign resp_z         = r_res_z;
  assign core_reset     = r_core_reset;
  assign core_is_direct = r_is_direct;
  assign core_x         = r_op_x;
  assign core_y         = r_op_y;
  assign core_z         = r_op_z;

endmodule
`default_nettype wire

// File: tb/tb_cordic_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cordic_arbiter
// Description : Self-checking bench for cordic_arbiter. A simple stand-in core
//               (fixed 15-cycle latency, distinguishable per-output function)
//               drives the core side; a transaction-level reference model
//               predicts grants, timing and results every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cordic_arbiter;

  localparam int W = 16;

  logic           clk = 1'b0;
  logic           reset;
  logic [1:0]     req_valid;
  logic [1:0]     req_ready;
  logic [1:0]     req_is_direct;
  logic [2*W-1:0] req_x, req_y, req_z;
  logic           resp_valid, resp_ready, resp_id, resp_err, busy;
  logic [W-1:0]   resp_x, resp_y, resp_z;
  logic           core_reset, core_is_direct, core_valid;
  logic [W-1:0]   core_x, core_y, core_z;
  logic [W-1:0]   core_x_out, core_y_out, core_z_out;

  // per-requester operands
  logic           op_dir [2];
  logic [W-1:0]   op_x   [2];
  logic [W-1:0]   op_y   [2];
  logic [W-1:0]   op_z   [2];

  assign req_is_direct = {op_dir[1], op_dir[0]};
  assign req_x         = {op_x[1], op_x[0]};
  assign req_y         = {op_y[1], op_y[0]};
  assign req_z         = {op_z[1], op_z[0]};

  always #5 clk = ~clk;

  cordic_arbiter #(.W(W), .TIMEOUT_CYCLES(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_is_direct  (req_is_direct),
    .req_x          (req_x),
    .req_y          (req_y),
    .req_z          (req_z),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_id        (resp_id),
    .resp_x         (resp_x),
    .resp_y         (resp_y),
    .resp_z         (resp_z),
    .resp_err       (resp_err),
    .busy           (busy),
    .core_reset     (core_reset),
    .core_is_direct (core_is_direct),
    .core_x         (core_x),
    .core_y         (core_y),
    .core_z         (core_z),
    .core_x_out     (core_x_out),
    .core_y_out     (core_y_out),
    .core_z_out     (core_z_out),
    .core_valid     (core_valid)
  );

  // Stand-in core function: each output depends differently on the inputs,
  // so swapped or stale operands/results show up.
  function automatic logic [3*W-1:0] core_fn(input logic dir, input logic [W-1:0] x,
                                             input logic [W-1:0] y, input logic [W-1:0] z);
    logic [W-1:0] ox, oy, oz;
    ox = x + y;
    oy = y ^ z ^ (dir ? 16'hA5A5 : 16'h0F0F);
    oz = z - x;
    return {ox, oy, oz};
  endfunction

  // Stand-in core: counts cycles out of reset, valid from the 15th on.
  logic [3:0]     core_cnt = 4'd0;
  logic [3*W-1:0] core_res;
  always @(posedge clk) begin
    if (core_reset)             core_cnt <= 4'd0;
    else if (core_cnt != 4'd15) core_cnt <= core_cnt + 4'd1;
  end
  assign core_res   = core_fn(core_is_direct, core_x, core_y, core_z);
  assign core_valid = !core_reset && (core_cnt >= 4'd14);
  assign core_x_out = core_valid ? core_res[3*W-1:2*W] : 16'hDEAD;
  assign core_y_out = core_valid ? core_res[2*W-1:W]   : 16'hBEEF;
  assign core_z_out = core_valid ? core_res[W-1:0]     : 16'hCAFE;

  // ------------------------------------------------------------------------
  // Checking
  // ------------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ------------------------------------------------------------------------
  // Reference model: idle/busy plus edges-since-accept; result due 16 edges
  // after the accept edge, idle again on the edge the result is taken.
  // ------------------------------------------------------------------------
  bit             m_busy;
  int             m_cnt;
  bit             m_last;
  bit             m_id;
  logic [3*W+W:0] m_ops;      // {dir, x, y, z}
  logic [3*W-1:0] m_res;
  bit             g_acc;
  bit             g_acc_id;

  task automatic model_reset();
    m_busy = 0; m_cnt = 0; m_last = 1; m_id = 0; m_ops = '0; m_res = '0; g_acc = 0;
  endtask

  // Called at a negedge with inputs already applied; returns at next negedge.
  task automatic run_cycle();
    logic [1:0] exp_ready;
    bit         g;
    bit         exp_resp;
    bit         in_run;
    #1;
    exp_ready = 2'b00;
    g = 0;
    if (!m_busy && req_valid != 2'b00) begin
      g = (req_valid == 2'b11) ? !m_last : req_valid[1];
      exp_ready[g] = 1'b1;
    end
    exp_resp = m_busy && (m_cnt >= 16);
    in_run   = m_busy && (m_cnt >= 1) && (m_cnt <= 15);
    check("req_ready",  req_ready,  exp_ready);
    check("busy",       busy,       m_busy);
    check("resp_valid", resp_valid, exp_resp);
    check("core_reset", core_reset, !in_run);
    check("resp_err",   resp_err,   1'b0);
    if (exp_resp) begin
      check("resp_id", resp_id, m_id);
      check("resp_xyz", {resp_x, resp_y, resp_z}, m_res);
    end
    if (m_busy && m_cnt <= 15)
      check("core_ops", {core_is_direct, core_x, core_y, core_z}, m_ops);
    @(posedge clk);
    g_acc = 0;
    if (!m_busy && req_valid != 2'b00) begin
      m_busy   = 1;
      m_cnt    = 0;
      m_last   = g;
      m_id     = g;
      m_ops    = {op_dir[g], op_x[g], op_y[g], op_z[g]};
      m_res    = core_fn(op_dir[g], op_x[g], op_y[g], op_z[g]);
      g_acc    = 1;
      g_acc_id = g;
    end else if (m_busy) begin
      if (m_cnt >= 16) begin
        if (resp_ready) m_busy = 0;
      end else begin
        m_cnt++;
      end
    end
    @(negedge clk);
  endtask

  task automatic new_ops(input int i);
    op_dir[i] = 1'($urandom_range(0, 1));
    op_x[i]   = 16'($urandom);
    op_y[i]   = 16'($urandom);
    op_z[i]   = 16'($urandom);
  endtask

  // Randomized requester/consumer behaviour; requests are only dropped
  // while the arbiter is busy, i.e. before they could have been accepted.
  task automatic rand_inputs(input int p_new, input int p_drop, input int p_rr);
    for (int i = 0; i < 2; i++) begin
      if (g_acc && int'(g_acc_id) == i) begin
        req_valid[i] = 1'b0;
        new_ops(i);
      end
      if (!req_valid[i]) begin
        if ($urandom_range(0, 99) < p_new) begin
          req_valid[i] = 1'b1;
          new_ops(i);
        end
      end else if (m_busy && $urandom_range(0, 99) < p_drop) begin
        req_valid[i] = 1'b0;
      end
    end
    resp_ready = ($urandom_range(0, 99) < p_rr);
  endtask

  task automatic clear_accepted();
    if (g_acc) req_valid[g_acc_id] = 1'b0;
  endtask

  // ------------------------------------------------------------------------
  // Stimulus
  // ------------------------------------------------------------------------
  initial begin
    reset      = 1'b1;
    req_valid  = 2'b00;
    resp_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      op_dir[i] = 1'b0; op_x[i] = '0; op_y[i] = '0; op_z[i] = '0;
    end
    model_reset();

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_core_reset", core_reset, 1'b1);
    check("rst_outputs", {busy, resp_valid, req_ready, resp_id, resp_err, core_is_direct}, '0);
    check("rst_result", {resp_x, resp_y, resp_z}, '0);
    check("rst_core_ops", {core_x, core_y, core_z}, '0);
    reset = 1'b0;
    @(negedge clk);

    // A alone, rotation; B arrives while busy; 12 cycles of response backpressure
    op_dir[0] = 1'b1; op_x[0] = 16'h1000; op_y[0] = 16'h0000; op_z[0] = 16'h0000;
    req_valid = 2'b01;
    for (int c = 0; c < 70; c++) begin
      if (c == 5) begin
        op_dir[1] = 1'b0; op_x[1] = 16'h1000; op_y[1] = 16'h1000; op_z[1] = 16'h0000;
        req_valid[1] = 1'b1;
      end
      if (c == 28) resp_ready = 1'b1;
      run_cycle();
      clear_accepted();
    end

    // Both held together repeatedly: alternating grants
    resp_ready = 1'b1;
    for (int c = 0; c < 80; c++) begin
      rand_inputs(100, 0, 100);
      run_cycle();
    end
    req_valid = 2'b00;
    for (int c = 0; c < 40; c++) begin
      run_cycle();
    end

    // Reset asserted five cycles into RUN
    for (int i = 0; i < 2; i++) new_ops(i);
    req_valid = 2'b11;
    for (int c = 0; c < 40 && !(m_busy && m_cnt == 6); c++) begin
      run_cycle();
      if (g_acc) req_valid = 2'b00;
    end
    check("mid_run_reached", {31'd0, m_busy}, 32'd1);
    reset = 1'b1;
    #1;
    check("arst_core_reset", core_reset, 1'b1);
    check("arst_resp_valid", resp_valid, 1'b0);
    check("arst_busy", busy, 1'b0);
    check("arst_core_ops", {core_is_direct, core_x, core_y, core_z}, '0);
    #2;
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    for (int i = 0; i < 2; i++) new_ops(i);
    req_valid = 2'b11;        // A must win first after reset
    for (int c = 0; c < 60; c++) begin
      run_cycle();
      clear_accepted();
    end

    // Randomized traffic under varying load and backpressure
    for (int c = 0; c < 800; c++) begin
      rand_inputs(30, 10, 40);
      run_cycle();
    end
    for (int c = 0; c < 800; c++) begin
      rand_inputs(60, 5, 80);
      run_cycle();
    end
    for (int c = 0; c < 600; c++) begin
      rand_inputs(90, 2, 15);
      run_cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
